// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one edge; MUL iterates shift-add for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Src1,
    input  logic [WIDTH-1:0] Src2,
    input  logic [SHW-1:0]   Shift,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : gWidthCheck
        $error("alu_seq: WIDTH must be a power of 2 and at least 4");
    end
    if (SHW != $clog2(WIDTH)) begin : gShwCheck
        $error("alu_seq: SHW must equal clog2(WIDTH)");
    end

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_OR   = 4'd2;
    localparam logic [3:0] F_SLL  = 4'd3;
    localparam logic [3:0] F_AND  = 4'd4;
    localparam logic [3:0] F_XOR  = 4'd5;
    localparam logic [3:0] F_SRL  = 4'd6;
    localparam logic [3:0] F_SRA  = 4'd7;
    localparam logic [3:0] F_SLT  = 4'd8;
    localparam logic [3:0] F_SLTU = 4'd9;
    localparam logic [3:0] F_MUL  = 4'd10;

    localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]   opB;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   aluRes;
    logic               aluCarry, aluOvf, aluErr;
    logic [WIDTH-1:0]   partial;

    // SUB reuses the adder with inverted B and carry-in, so carry-out means "no borrow".
    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        aluErr   = 1'b0;
        opB      = (func == F_SUB) ? ~Src2 : Src2;
        sum      = {1'b0, Src1} + {1'b0, opB} + {{WIDTH{1'b0}}, (func == F_SUB)};
        case (func)
            F_ADD, F_SUB: begin
                aluRes   = sum[WIDTH-1:0];
                aluCarry = sum[WIDTH];
                aluOvf   = (Src1[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != Src1[WIDTH-1]);
            end
            F_OR:   aluRes = Src1 | Src2;
            F_SLL:  aluRes = Src1 << Shift;
            F_AND:  aluRes = Src1 & Src2;
            F_XOR:  aluRes = Src1 ^ Src2;
            F_SRL:  aluRes = Src1 >> Shift;
            F_SRA:  aluRes = $signed(Src1) >>> Shift;
            F_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(Src1) < $signed(Src2))};
            F_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (Src1 < Src2)};
            F_MUL:  aluRes = '0;
            default: aluErr = 1'b1;
        endcase
    end

    assign partial = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (func == F_MUL) begin
                        acc_d    = '0;
                        mcand_d  = Src1;
                        mplier_d = Src2;
                        cnt_d    = CNT_INIT;
                        state_d  = BUSY;
                    end else begin
                        result_d = aluRes;
                        zero_d   = !aluErr && (aluRes == '0);
                        carry_d  = aluCarry;
                        ovf_d    = aluOvf;
                        err_d    = aluErr;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                acc_d    = partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    result_d = partial;
                    zero_d   = (partial == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against
// an arithmetic reference model.
module tb_alu_seq;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  Src1;
    logic [W-1:0]  Src2;
    logic [SW-1:0] Shift;
    logic [3:0]    func;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Result;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          err;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Src1     (Src1),
        .Src2     (Src2),
        .Shift    (Shift),
        .func     (func),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result   (Result),
        .zero     (zero),
        .carry    (carry),
        .ovf      (ovf),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: results derived from the operation definitions with wide arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic [3:0] f,
                                  output logic [31:0] r, output logic [3:0] flags);
        logic z, c, o, e;
        longint unsigned wide;
        c = 1'b0; o = 1'b0; e = 1'b0; r = '0;
        case (f)
            4'd0: begin
                wide = longint'(a) + longint'(b);
                r = wide[31:0];
                c = wide[32];
                o = (int'(a) >= 0 && int'(b) >= 0 && int'(r) < 0) ||
                    (int'(a) < 0 && int'(b) < 0 && int'(r) >= 0);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                o = (longint'(int'(a)) - longint'(int'(b))) != longint'(int'(r));
            end
            4'd2:  r = a | b;
            4'd3:  r = a << sh;
            4'd4:  r = a & b;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> sh;
            4'd7:  r = int'(a) >>> sh;
            4'd8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                wide = longint'(a) * longint'(b);
                r = wide[31:0];
            end
            default: e = 1'b1;
        endcase
        z = !e && (r == 32'd0);
        flags = {z, c, o, e};
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [3:0] f);
        int waitCnt;
        logic busyOk;
        waitCnt = 0;
        while (in_ready !== 1'b1 && waitCnt < 100) begin
            tick();
            waitCnt++;
        end
        check({tag, "_ready"}, in_ready, 1'b1);
        Src1 = a; Src2 = b; Shift = sh; func = f; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        Src1 = $urandom; Src2 = $urandom; Shift = SW'($urandom); func = 4'($urandom);
        if (f == 4'd10) begin
            busyOk = 1'b1;
            for (int i = 1; i < W; i++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) busyOk = 1'b0;
                tick();
            end
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busyOk = 1'b0;
            check({tag, "_busy"}, busyOk, 1'b1);
            tick();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic [3:0] f, input int hold);
        logic [31:0] expR;
        logic [3:0]  expF;
        logic        stable;
        model(a, b, sh, f, expR, expF);
        check({tag, "_valid"}, {in_ready, out_valid}, 2'b01);
        check({tag, "_result"}, Result, expR);
        check({tag, "_flags"}, {zero, carry, ovf, err}, expF);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                tick();
                if (out_valid !== 1'b1 || Result !== expR || {zero, carry, ovf, err} !== expF)
                    stable = 1'b0;
            end
            check({tag, "_hold"}, stable, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, {in_ready, out_valid}, 2'b10);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] f, input int hold);
        applyStimulus(tag, a, b, sh, f);
        checkOutput(tag, a, b, sh, f, hold);
    endtask

    initial begin
        logic noValid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Src1 = '0; Src2 = '0; Shift = '0; func = '0;
        repeat (2) tick();
        check("reset_hs", {in_ready, out_valid}, 2'b10);
        check("reset_result", Result, 32'd0);
        check("reset_flags", {zero, carry, ovf, err}, 4'b1000);
        rst = 1'b0;
        tick();

        runOp("add_ovf", 32'h7FFF_FFFF, 32'd1, 5'd0, 4'd0, 5);
        runOp("add_carry", 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd0, 0);
        runOp("sub_eq", 32'd5, 32'd5, 5'd0, 4'd1, 0);
        runOp("sub_ovf", 32'h8000_0000, 32'd1, 5'd0, 4'd1, 0);
        runOp("slt", 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd8, 0);
        runOp("sltu", 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd9, 0);
        runOp("srl", 32'h8000_0000, 32'd0, 5'd4, 4'd6, 0);
        runOp("sra", 32'h8000_0000, 32'd0, 5'd4, 4'd7, 0);
        runOp("sll", 32'd1, 32'd0, 5'd31, 4'd3, 0);
        runOp("logic_or", 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 4'd2, 0);
        runOp("logic_and", 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 4'd4, 0);
        runOp("logic_xor", 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 4'd5, 0);
        runOp("mul", 32'h0001_0003, 32'h0000_0005, 5'd0, 4'd10, 3);
        runOp("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4'd10, 0);
        runOp("mul_zero", 32'h1234_5678, 32'd0, 5'd0, 4'd10, 0);

        // Reset ten cycles into a multiply must discard it without any output.
        Src1 = 32'd7; Src2 = 32'd9; Shift = '0; func = 4'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midmul_hs", {in_ready, out_valid}, 2'b10);
        check("midmul_result", Result, 32'd0);
        check("midmul_flags", {zero, carry, ovf, err}, 4'b1000);
        noValid = 1'b1;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) noValid = 1'b0;
        end
        check("midmul_noout", noValid, 1'b1);

        runOp("illegal", 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 4'd13, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic [4:0]  rs;
            logic [3:0]  rf;
            ra = $urandom; rb = $urandom; rs = 5'($urandom); rf = 4'($urandom_range(0, 15));
            if (i % 4 == 0) rb = ra;
            runOp($sformatf("rnd%0d_f%0d", i, rf), ra, rb, rs, rf, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
